// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the fetch-stage program-counter unit.
// Optional trap input is enabled with the PC_TRAP_EN macro.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_PC    = 32'h4000_0000;
    localparam int          DEF_INSTR_BYTES = 4;

    // Low target bits that must be zero for a legal instruction address.
    localparam logic [1:0]  ALIGN_LSB_MASK  = 2'b11;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side bus of the PC unit: stall, redirect channels and fetch outputs.
// PC_TRAP_EN adds the trap / trap_vec pair.
interface pc_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int REDIRECT_CH = 2
);
    logic                            stall;
    logic [REDIRECT_CH-1:0]          redir_valid;
    logic [REDIRECT_CH*PC_WIDTH-1:0] redir_target;
`ifdef PC_TRAP_EN
    logic                            trap;
    logic [PC_WIDTH-1:0]             trap_vec;
`endif
    logic [PC_WIDTH-1:0]             fetch_addr;
    logic [PC_WIDTH-1:0]             pc;
    logic                            pc_valid;
    logic                            flush;
    logic                            misalign;

`ifdef PC_TRAP_EN
    modport master (output stall, redir_valid, redir_target, trap, trap_vec,
                    input  fetch_addr, pc, pc_valid, flush, misalign);
    modport slave  (input  stall, redir_valid, redir_target, trap, trap_vec,
                    output fetch_addr, pc, pc_valid, flush, misalign);
`else
    modport master (output stall, redir_valid, redir_target,
                    input  fetch_addr, pc, pc_valid, flush, misalign);
    modport slave  (input  stall, redir_valid, redir_target,
                    output fetch_addr, pc, pc_valid, flush, misalign);
`endif
endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector; channel 0 wins over higher indices.
module pc_redirect_arb #(
    parameter int PC_WIDTH    = 32,
    parameter int REDIRECT_CH = 2
) (
    input  logic [REDIRECT_CH-1:0]          i_valid,
    input  logic [REDIRECT_CH*PC_WIDTH-1:0] i_target,
    output logic                            o_any_valid,
    output logic [PC_WIDTH-1:0]             o_target
);

    // Scan from the lowest priority upward so the lowest asserted index is left standing.
    always_comb begin
        o_any_valid = |i_valid;
        o_target    = '0;
        for (int i = REDIRECT_CH - 1; i >= 0; i--) begin
            if (i_valid[i]) o_target = i_target[i*PC_WIDTH +: PC_WIDTH];
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: reset launch, sequential advance, redirect
// arbitration and a one-entry pending buffer for redirects seen while stalled.
// Define PC_TRAP_EN to add a trap source above all redirects.
//
// state  | meaning
// IDLE   | held in reset; outputs at reset values, pending buffer empty
// LAUNCH | first cycle after reset; presents RESET_PC, redirects ignored
// RUN    | normal fetch; pc/pc_valid track the returning instruction
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int                  REDIRECT_CH = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    pc_state_t           r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pend_tgt, w_pend_tgt_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
`ifdef PC_TRAP_EN
    logic                r_pend_trap, w_pend_trap_nxt;
`endif
    logic                w_arb_valid;
    logic [PC_WIDTH-1:0] w_arb_tgt;
    logic [PC_WIDTH-1:0] w_raw_tgt;
    logic [PC_WIDTH-1:0] w_fetch;
    logic                w_apply;
    logic                w_pc_load;
    logic                w_pc_valid;
    logic                w_flush;
    logic                w_misalign;

    pc_redirect_arb #(
        .PC_WIDTH    (PC_WIDTH),
        .REDIRECT_CH (REDIRECT_CH)
    ) u_arb (
        .i_valid     (bus.redir_valid),
        .i_target    (bus.redir_target),
        .o_any_valid (w_arb_valid),
        .o_target    (w_arb_tgt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, next-PC selection, pending-buffer update and per-cycle outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch          = RESET_PC;
        w_raw_tgt        = '0;
        w_apply          = 1'b0;
        w_pc_load        = 1'b0;
        w_pc_valid       = 1'b0;
        w_flush          = 1'b0;
        w_misalign       = 1'b0;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_tgt_nxt   = r_pend_tgt;
`ifdef PC_TRAP_EN
        w_pend_trap_nxt  = r_pend_trap;
`endif
        case (r_state)
            ST_IDLE: begin
                w_state_nxt      = ST_LAUNCH;
                w_pend_valid_nxt = 1'b0;
`ifdef PC_TRAP_EN
                w_pend_trap_nxt  = 1'b0;
`endif
            end
            ST_LAUNCH: begin
                if (!bus.stall) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_pc_valid = 1'b1;
                if (bus.stall) begin
                    // Memory re-reads the current PC; remember the newest target.
                    w_fetch = r_pc;
`ifdef PC_TRAP_EN
                    if (bus.trap) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_tgt_nxt   = bus.trap_vec;
                        w_pend_trap_nxt  = 1'b1;
                    end else if (w_arb_valid && !r_pend_trap) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_tgt_nxt   = w_arb_tgt;
                    end
`else
                    if (w_arb_valid) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_tgt_nxt   = w_arb_tgt;
                    end
`endif
                end else begin
                    // Whatever is pending is consumed or superseded this cycle.
                    w_pc_load        = 1'b1;
                    w_pend_valid_nxt = 1'b0;
                    w_apply          = 1'b1;
`ifdef PC_TRAP_EN
                    w_pend_trap_nxt  = 1'b0;
                    if (bus.trap)                         w_raw_tgt = bus.trap_vec;
                    else if (r_pend_valid && r_pend_trap) w_raw_tgt = r_pend_tgt;
                    else
`endif
                    if (w_arb_valid)       w_raw_tgt = w_arb_tgt;
                    else if (r_pend_valid) w_raw_tgt = r_pend_tgt;
                    else                   w_apply   = 1'b0;

                    if (w_apply) begin
                        w_fetch    = w_raw_tgt & ~PC_WIDTH'(ALIGN_LSB_MASK);
                        w_flush    = 1'b1;
                        w_misalign = |(w_raw_tgt[1:0] & ALIGN_LSB_MASK);
                    end else begin
                        w_fetch    = r_pc + PC_WIDTH'(INSTR_BYTES);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // PC register follows the fetch address whenever fetch advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_pc <= RESET_PC;
        else if (w_pc_load) r_pc <= w_fetch;
    end

    // Pending redirect buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_tgt   <= '0;
`ifdef PC_TRAP_EN
            r_pend_trap  <= 1'b0;
`endif
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_tgt   <= w_pend_tgt_nxt;
`ifdef PC_TRAP_EN
            r_pend_trap  <= w_pend_trap_nxt;
`endif
        end
    end

    assign bus.fetch_addr = w_fetch;
    assign bus.pc         = r_pc;
    assign bus.pc_valid   = w_pc_valid;
    assign bus.flush      = w_flush;
    assign bus.misalign   = w_misalign;

endmodule
